// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the regfile, decode and write-back arbiter.
//   REG_ADDR_W : register address width
//   REG_DATA_W : register data width
//   NUM_REGS   : number of architectural registers
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of write-back request, reservation, regfile-port and scoreboard signals.
//   master : producers / issue stage side (drives requests and reservations)
//   slave  : write-back arbiter side (drives grants, regfile port, pending bitmap)
// Requester slot i occupies req_addr[i*ADDR_W +: ADDR_W] and req_data[i*DATA_W +: DATA_W].
interface regfile_wb_arbiter_if #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    rsv_valid;
  logic [ADDR_W-1:0]       rsv_addr;
  logic                    wb_we;
  logic [ADDR_W-1:0]       wb_waddr;
  logic [DATA_W-1:0]       wb_wdata;
  logic [(1<<ADDR_W)-1:0]  pending;

  modport master (
    output req_valid, req_addr, req_data, rsv_valid, rsv_addr,
    input  req_ready, wb_we, wb_waddr, wb_wdata, pending
  );

  modport slave (
    input  req_valid, req_addr, req_data, rsv_valid, rsv_addr,
    output req_ready, wb_we, wb_waddr, wb_wdata, pending
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with rotating priority.
//   clk, reset : clock, asynchronous active-high reset
//   req_i      : request vector
//   advance_i  : a grant is being accepted this cycle; pointer moves past the winner
//   gnt_o      : one-hot grant (all-zero when no request)
//   gnt_idx_o  : index of the granted requester
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_i,
  input  logic            advance_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] cand_idx;
  int unsigned     cand;
  logic            found;

  // Search starts at ptr_q and wraps modulo N; first requester found wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IdxW'(cand);
      if (!found && req_i[cand_idx]) begin
        found            = 1'b1;
        gnt_o[cand_idx]  = 1'b1;
        gnt_idx_o        = cand_idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (gnt_idx_o == IdxW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and register scoreboard for the regfile's single write port.
//   clk   : clock; the regfile samples wb_* on the negedge following each posedge
//   reset : asynchronous, active-high
//   bus   : slave side of regfile_wb_arbiter_if
//           req_valid/req_addr/req_data in, req_ready out (one-hot grant)
//           rsv_valid/rsv_addr in (destination reservation from issue)
//           wb_we/wb_waddr/wb_wdata out (registered regfile write port)
//           pending out (per-register outstanding-write bitmap)
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned DATA_W = REG_DATA_W
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned IdxW    = $clog2(N_REQ);
  localparam int unsigned NumRegs = 1 << ADDR_W;

  logic [N_REQ-1:0]   gnt;
  logic [IdxW-1:0]    gnt_idx;
  logic               accept;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_data;

  logic               wb_we_q, wb_we_d;
  logic [ADDR_W-1:0]  wb_waddr_q, wb_waddr_d;
  logic [DATA_W-1:0]  wb_wdata_q, wb_wdata_d;
  logic [NumRegs-1:0] pending_q, pending_d;

  // No back-pressure downstream, so any valid request is accepted immediately.
  assign accept = |bus.req_valid;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .req_i     (bus.req_valid),
    .advance_i (accept),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign bus.req_ready = gnt;

  always_comb begin
    win_addr = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
    win_data = bus.req_data[gnt_idx*DATA_W +: DATA_W];
  end

  // r0 writes complete the handshake but never reach the regfile.
  always_comb begin
    wb_we_d    = 1'b0;
    wb_waddr_d = wb_waddr_q;
    wb_wdata_d = wb_wdata_q;
    if (accept) begin
      wb_we_d    = (win_addr != '0);
      wb_waddr_d = win_addr;
      wb_wdata_d = win_data;
    end
  end

  // Clear from the completing write, then set from a new reservation so set wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_we_q) pending_d[wb_waddr_q] = 1'b0;
    if (bus.rsv_valid && (bus.rsv_addr != '0)) pending_d[bus.rsv_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_we_q    <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
      pending_q  <= '0;
    end else begin
      wb_we_q    <= wb_we_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wdata_q <= wb_wdata_d;
      pending_q  <= pending_d;
    end
  end

  assign bus.wb_we    = wb_we_q;
  assign bus.wb_waddr = wb_waddr_q;
  assign bus.wb_wdata = wb_wdata_q;
  assign bus.pending  = pending_q;

endmodule
